// File: rtl/hamming_secded_engine.sv
// Hamming (16,11) SECDED block engine: walks NUM_MSG items in byte memory, encoding or decoding each.
// Optional HAMMING_ERR_CNT_EN builds the per-run single/double error counters.
module hamming_secded_engine #(
   parameter int ADDR_W   = 8,
   parameter int NUM_MSG  = 15,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 30
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic              Mode,
   output logic              Done,
   output logic [ADDR_W-1:0] Mem_addr,
   output logic              Mem_we,
   output logic [7:0]        Mem_wdata,
   input  logic [7:0]        Mem_rdata,
   output logic [7:0]        Err1_cnt,
   output logic [7:0]        Err2_cnt
);
   // state | meaning
   // IDLE  | waiting for Start, Done holds its level
   // RD_LO | source low-byte address out
   // RD_HI | low byte arrives, source high-byte address out
   // CAP   | high byte arrives
   // CALC  | encode/decode, result registered, error counters step
   // WR_LO | result low byte written
   // WR_HI | result high byte written, advance or finish
   // FIN   | run complete, Done rises on exit
   typedef enum logic [2:0] {
      IDLE, RD_LO, RD_HI, CAP, CALC, WR_LO, WR_HI, FIN
   } state_t;

   localparam logic [ADDR_W-1:0] SRC_B    = ADDR_W'(SRC_BASE);
   localparam logic [ADDR_W-1:0] DST_B    = ADDR_W'(DST_BASE);
   localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NUM_MSG - 1);

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] left_q, left_d;
   logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
   logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
   logic [7:0]        lo_q, lo_d;
   logic [7:0]        hi_q, hi_d;
   logic [15:0]       res_q, res_d;

   function automatic logic [3:0] syndrome(input logic [15:0] c);
      logic [3:0] s;
      s = 4'd0;
      for (int i = 1; i < 16; i++) begin
         if (c[i]) s = s ^ 4'(i);
      end
      return s;
   endfunction

   logic [10:0] enc_msg;
   logic [15:0] enc_cw;
   logic [3:0]  enc_syn;
   logic [15:0] dec_raw;
   logic [15:0] dec_fix;
   logic [3:0]  dec_syn;
   logic [1:0]  dec_flag;
   logic [15:0] dec_res;

   // Parity bits are the syndrome of the codeword built with them zeroed.
   always_comb begin
      enc_msg = {hi_q[2:0], lo_q};
      enc_cw  = {enc_msg[10:4], 1'b0, enc_msg[3:1], 1'b0, enc_msg[0], 3'b000};
      enc_syn = syndrome(enc_cw);
      enc_cw[8] = enc_syn[3];
      enc_cw[4] = enc_syn[2];
      enc_cw[2] = enc_syn[1];
      enc_cw[1] = enc_syn[0];
      enc_cw[0] = ^enc_cw[15:1];

      dec_raw  = {hi_q, lo_q};
      dec_fix  = dec_raw;
      dec_syn  = syndrome(dec_raw);
      dec_flag = 2'b00;
      if (^dec_raw) begin
         dec_flag = 2'b01;
         dec_fix[dec_syn] = ~dec_fix[dec_syn];
      end else if (dec_syn != 4'd0) begin
         dec_flag = 2'b10;
      end
      dec_res = {dec_flag, 3'b000, dec_fix[15:9], dec_fix[7:5], dec_fix[3]};
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         mode_q    <= 1'b0;
         done_q    <= 1'b0;
         left_q    <= '0;
         src_ptr_q <= '0;
         dst_ptr_q <= '0;
         lo_q      <= 8'h00;
         hi_q      <= 8'h00;
         res_q     <= 16'h0000;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         done_q    <= done_d;
         left_q    <= left_d;
         src_ptr_q <= src_ptr_d;
         dst_ptr_q <= dst_ptr_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         res_q     <= res_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      done_d    = done_q;
      left_d    = left_q;
      src_ptr_d = src_ptr_q;
      dst_ptr_d = dst_ptr_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      res_d     = res_q;
      Mem_addr  = '0;
      Mem_we    = 1'b0;
      Mem_wdata = 8'h00;
      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d   = RD_LO;
               mode_d    = Mode;
               done_d    = 1'b0;
               left_d    = LAST_CNT;
               src_ptr_d = SRC_B;
               dst_ptr_d = DST_B;
            end
         end
         RD_LO: begin
            Mem_addr = src_ptr_q;
            state_d  = RD_HI;
         end
         RD_HI: begin
            Mem_addr = src_ptr_q + ADDR_W'(1);
            lo_d     = Mem_rdata;
            state_d  = CAP;
         end
         CAP: begin
            hi_d    = Mem_rdata;
            state_d = CALC;
         end
         CALC: begin
            res_d   = mode_q ? dec_res : enc_cw;
            state_d = WR_LO;
         end
         WR_LO: begin
            Mem_addr  = dst_ptr_q;
            Mem_we    = 1'b1;
            Mem_wdata = res_q[7:0];
            state_d   = WR_HI;
         end
         WR_HI: begin
            Mem_addr  = dst_ptr_q + ADDR_W'(1);
            Mem_we    = 1'b1;
            Mem_wdata = res_q[15:8];
            if (left_q == '0) begin
               state_d = FIN;
            end else begin
               left_d    = left_q - ADDR_W'(1);
               src_ptr_d = src_ptr_q + ADDR_W'(2);
               dst_ptr_d = dst_ptr_q + ADDR_W'(2);
               state_d   = RD_LO;
            end
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign Done = done_q;

`ifdef HAMMING_ERR_CNT_EN
   logic [7:0] err1_q, err1_d;
   logic [7:0] err2_q, err2_d;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         err1_q <= 8'h00;
         err2_q <= 8'h00;
      end else begin
         err1_q <= err1_d;
         err2_q <= err2_d;
      end
   end

   always_comb begin
      err1_d = err1_q;
      err2_d = err2_q;
      if (state_q == IDLE && Start) begin
         err1_d = 8'h00;
         err2_d = 8'h00;
      end else if (state_q == CALC && mode_q) begin
         if (dec_flag == 2'b01 && err1_q != 8'hFF) err1_d = err1_q + 8'd1;
         if (dec_flag == 2'b10 && err2_q != 8'hFF) err2_d = err2_q + 8'd1;
      end
   end

   assign Err1_cnt = err1_q;
   assign Err2_cnt = err2_q;
`else
   assign Err1_cnt = 8'h00;
   assign Err2_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_hamming_secded_engine.sv
// Bench for hamming_secded_engine: byte memory model, independent SECDED reference, result scoreboard.
module tb_hamming_secded_engine;
   localparam int N   = 15;
   localparam int DST = 30;

`ifdef HAMMING_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       Start;
   logic       Mode;
   logic       Done;
   logic [7:0] Mem_addr;
   logic       Mem_we;
   logic [7:0] Mem_wdata;
   logic [7:0] Mem_rdata;
   logic [7:0] Err1_cnt;
   logic [7:0] Err2_cnt;

   logic [7:0]  mem [0:255];
   logic        tb_we;
   logic [7:0]  tb_addr;
   logic [7:0]  tb_data;
   int          wr_cnt = 0;
   int          checks = 0;
   int          failures = 0;
   logic [15:0] src_w [0:N-1];
   logic [15:0] exp_q [$];
   int          exp_e1;
   int          exp_e2;

   hamming_secded_engine #(
      .ADDR_W(8), .NUM_MSG(N), .SRC_BASE(0), .DST_BASE(DST)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mode(Mode), .Done(Done),
      .Mem_addr(Mem_addr), .Mem_we(Mem_we), .Mem_wdata(Mem_wdata), .Mem_rdata(Mem_rdata),
      .Err1_cnt(Err1_cnt), .Err2_cnt(Err2_cnt)
   );

   always #5 Clk = ~Clk;

   // Synchronous-read byte memory; the bench preloads through its own write port while the engine is idle.
   always @(posedge Clk) begin
      Mem_rdata <= mem[Mem_addr];
      if (tb_we) begin
         mem[tb_addr] <= tb_data;
      end else if (Mem_we) begin
         mem[Mem_addr] <= Mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
   end

   function automatic logic [15:0] ref_enc(input logic [10:0] m);
      logic [15:0] c;
      c = 16'h0000;
      c[3] = m[0];  c[5] = m[1];  c[6] = m[2];  c[7] = m[3];
      c[9] = m[4];  c[10] = m[5]; c[11] = m[6]; c[12] = m[7];
      c[13] = m[8]; c[14] = m[9]; c[15] = m[10];
      c[1] = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
      c[2] = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
      c[4] = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
      c[8] = ^c[15:9];
      c[0] = ^c[15:1];
      return c;
   endfunction

   function automatic logic [15:0] ref_dec(input logic [15:0] c_in);
      logic [15:0] c;
      logic [3:0]  s;
      logic [1:0]  f;
      c = c_in;
      s[0] = c[1] ^ c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
      s[1] = c[2] ^ c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
      s[2] = c[4] ^ c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
      s[3] = ^c[15:8];
      if (^c) begin
         f = 2'b01;
         c[s] = ~c[s];
      end else if (s != 4'd0) begin
         f = 2'b10;
      end else begin
         f = 2'b00;
      end
      return {f, 3'b000, c[15], c[14], c[13], c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] rd16(input int a);
      return {mem[8'(a + 1)], mem[8'(a)]};
   endfunction

   task automatic poke(input int a, input logic [7:0] d);
      tb_addr = 8'(a);
      tb_data = d;
      tb_we   = 1'b1;
      @(posedge Clk); #1;
      tb_we   = 1'b0;
   endtask

   task automatic load_src();
      for (int i = 0; i < N; i++) begin
         poke(2 * i, src_w[i][7:0]);
         poke(2 * i + 1, src_w[i][15:8]);
      end
   endtask

   task automatic clear_dst();
      for (int i = 0; i < 2 * N; i++) poke(DST + i, 8'hA5);
   endtask

   task automatic push_exp(input logic mode, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back(mode ? ref_dec(src_w[i]) : ref_enc(src_w[i][10:0]));
   endtask

   task automatic check_results(input int n);
      logic [15:0] e;
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         chk($sformatf("item%0d", i), 32'(rd16(DST + 2 * i)), 32'(e));
      end
   endtask

   // Start held for `hold` edges, optional extra one-cycle pulse at edge pulse_at; Mode flipped after launch.
   task automatic run(input logic mode, input int hold, input int pulse_at, output int cyc);
      Mode  = mode;
      Start = 1'b1;
      @(posedge Clk); #1;
      Mode = ~mode;
      chk("err1_clr", 32'(Err1_cnt), 32'd0);
      chk("err2_clr", 32'(Err2_cnt), 32'd0);
      cyc = -1;
      for (int k = 1; k <= 400; k++) begin
         Start = (k < hold) || (k == pulse_at);
         @(posedge Clk); #1;
         if (Done) begin
            cyc = k;
            break;
         end
      end
      Start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int k = 1; k <= 400; k++) begin
         @(posedge Clk); #1;
         if (Done) begin
            cyc = k;
            break;
         end
      end
   endtask

   initial begin
      int cyc;
      int base;
      logic [15:0] r;
      Reset_n = 1'b0;
      Start   = 1'b0;
      Mode    = 1'b0;
      tb_we   = 1'b0;
      tb_addr = 8'h00;
      tb_data = 8'h00;
      #2;
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_we", 32'(Mem_we), 32'd0);
      chk("rst_addr", 32'(Mem_addr), 32'd0);
      chk("rst_wdata", 32'(Mem_wdata), 32'd0);
      chk("rst_err1", 32'(Err1_cnt), 32'd0);
      chk("rst_err2", 32'(Err2_cnt), 32'd0);
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;

      // Encode: corner messages then random ones.
      src_w[0] = 16'h0000;
      src_w[1] = 16'h07FF;
      src_w[2] = 16'h0001;
      for (int i = 3; i < N; i++) src_w[i] = {5'b0, 11'($urandom_range(0, 2047))};
      load_src();
      clear_dst();
      push_exp(1'b0, N);
      base = wr_cnt;
      run(1'b0, 1, 0, cyc);
      chk("enc_latency", 32'(cyc), 32'd91);
      chk("enc_writes", 32'(wr_cnt - base), 32'd30);
      chk("enc_c0", 32'(rd16(DST)), 32'h0000);
      chk("enc_c1", 32'(rd16(DST + 2)), 32'hFFFF);
      chk("enc_c2", 32'(rd16(DST + 4)), 32'h000F);
      check_results(N);

      // Second run with unchanged source must reproduce the same codewords.
      clear_dst();
      push_exp(1'b0, N);
      run(1'b0, 1, 0, cyc);
      chk("rerun_latency", 32'(cyc), 32'd91);
      check_results(N);

      // Decode: fixed single/double/clean cases then a mix of corrupted codewords.
      src_w[0] = 16'h040F;
      src_w[1] = 16'h000E;
      src_w[2] = 16'h0009;
      src_w[3] = 16'hFFFF;
      for (int i = 4; i < N; i++) begin
         int b1;
         int b2;
         r  = ref_enc(11'($urandom_range(0, 2047)));
         b1 = $urandom_range(0, 15);
         b2 = (b1 + 1 + $urandom_range(0, 14)) % 16;
         if (i % 3 == 0) r[b1] = ~r[b1];
         if (i % 3 == 1) begin
            r[b1] = ~r[b1];
            r[b2] = ~r[b2];
         end
         src_w[i] = r;
      end
      exp_e1 = 0;
      exp_e2 = 0;
      for (int i = 0; i < N; i++) begin
         r = ref_dec(src_w[i]);
         if (r[15:14] == 2'b01) exp_e1++;
         if (r[15:14] == 2'b10) exp_e2++;
      end
      load_src();
      clear_dst();
      push_exp(1'b1, N);
      run(1'b1, 1, 0, cyc);
      chk("dec_latency", 32'(cyc), 32'd91);
      chk("dec_single", 32'(rd16(DST)), 32'h4001);
      chk("dec_p0", 32'(rd16(DST + 2)), 32'h4001);
      chk("dec_double", 32'(rd16(DST + 4)), 32'h8001);
      chk("dec_clean", 32'(rd16(DST + 6)), 32'h07FF);
      check_results(N);
      chk("dec_err1", 32'(Err1_cnt), 32'(CNT_EN ? exp_e1 : 0));
      chk("dec_err2", 32'(Err2_cnt), 32'(CNT_EN ? exp_e2 : 0));

      // Encode the same source: upper bits ignored; long Start plus a mid-run pulse launch one run.
      push_exp(1'b0, N);
      base = wr_cnt;
      run(1'b0, 5, 30, cyc);
      chk("long_start_latency", 32'(cyc), 32'd91);
      repeat (10) @(posedge Clk);
      #1;
      chk("done_holds", 32'(Done), 32'd1);
      chk("long_start_writes", 32'(wr_cnt - base), 32'd30);
      check_results(N);

      // Start raised before Done: ignored in FIN, accepted the cycle after Done.
      push_exp(1'b0, N);
      base = wr_cnt;
      Mode  = 1'b0;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int k = 1; k < 90; k++) begin
         @(posedge Clk); #1;
      end
      Start = 1'b1;
      @(posedge Clk); #1;
      chk("done_not_early", 32'(Done), 32'd0);
      @(posedge Clk); #1;
      chk("done_at_91", 32'(Done), 32'd1);
      @(posedge Clk); #1;
      chk("restart_clears_done", 32'(Done), 32'd0);
      Start = 1'b0;
      wait_done(cyc);
      chk("restart_latency", 32'(cyc), 32'd91);
      chk("two_run_writes", 32'(wr_cnt - base), 32'd60);
      check_results(N);

      // Reset while item 3 is about to be written.
      clear_dst();
      push_exp(1'b0, 3);
      base  = wr_cnt;
      Mode  = 1'b0;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         @(posedge Clk); #1;
      end
      chk("pre_rst_we", 32'(Mem_we), 32'd1);
      chk("pre_rst_addr", 32'(Mem_addr), 32'(DST + 6));
      #2 Reset_n = 1'b0;
      #1;
      chk("abort_done", 32'(Done), 32'd0);
      chk("abort_we", 32'(Mem_we), 32'd0);
      chk("abort_addr", 32'(Mem_addr), 32'd0);
      chk("abort_wdata", 32'(Mem_wdata), 32'd0);
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      chk("abort_writes", 32'(wr_cnt - base), 32'd6);
      check_results(3);
      chk("item3_untouched", 32'(rd16(DST + 6)), 32'hA5A5);

      push_exp(1'b0, N);
      run(1'b0, 1, 0, cyc);
      chk("post_rst_latency", 32'(cyc), 32'd91);
      check_results(N);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
